// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply (shift-add) and divide (restoring) unit; hi/lo load WIDTH edges after accept, done pulses one cycle later.
// No queueing: a start that arrives while busy is dropped, and flush aborts an in-flight op without touching hi/lo.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rdata
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a, mcand, acc, sh;
   logic             is_div, div_zero, neg_q, neg_r;

   logic             dec_md, dec_signed, dec_div, dec_mthi, dec_mtlo;
   logic             can_start, accept_md, accept_mthi, accept_mtlo, stepping, finish;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic [WIDTH:0]     msum, rem_sh;
   logic               borrow;
   logic [WIDTH-1:0]   acc_nx, sh_nx, quo, rem, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod, prod_s;

   always_comb begin
      dec_md     = 1'b0;
      dec_signed = 1'b0;
      dec_div    = 1'b0;
      dec_mthi   = 1'b0;
      dec_mtlo   = 1'b0;
      case (funct)
         F_MULT:  begin dec_md = 1'b1; dec_signed = 1'b1; end
         F_MULTU: dec_md = 1'b1;
         F_DIV:   begin dec_md = 1'b1; dec_signed = 1'b1; dec_div = 1'b1; end
         F_DIVU:  begin dec_md = 1'b1; dec_div = 1'b1; end
         F_MTHI:  dec_mthi = 1'b1;
         F_MTLO:  dec_mtlo = 1'b1;
         default: ;
      endcase
   end

   assign can_start   = (state != S_RUN);
   assign accept_md   = start & can_start & dec_md;
   assign accept_mthi = start & can_start & dec_mthi;
   assign accept_mtlo = start & can_start & dec_mtlo;
   assign stepping    = (state == S_RUN) & ~flush;
   assign finish      = stepping & (cnt == LAST);

   // Signed ops iterate on magnitudes; signs are re-applied to the final result.
   assign a_neg = dec_signed & a[WIDTH-1];
   assign b_neg = dec_signed & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: state_nx = accept_md ? S_RUN : S_IDLE;
         S_RUN: begin
            if (flush)
               state_nx = S_IDLE;
            else if (cnt == LAST)
               state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // One iteration: acc holds the product high half / partial remainder,
   // sh holds the multiplier being shifted out / dividend turning into quotient.
   always_comb begin
      msum   = {1'b0, acc} + (sh[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      rem_sh = {acc, sh[WIDTH-1]};
      borrow = (rem_sh < {1'b0, mcand});
      acc_nx = acc;
      sh_nx  = sh;
      if (is_div) begin
         if (borrow) begin
            acc_nx = rem_sh[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], 1'b0};
         end else begin
            acc_nx = rem_sh[WIDTH-1:0] - mcand;
            sh_nx  = {sh[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_nx = msum[WIDTH:1];
         sh_nx  = {msum[0], sh[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod   = {acc_nx, sh_nx};
      prod_s = neg_q ? -prod : prod;
      quo    = neg_q ? -sh_nx : sh_nx;
      rem    = neg_r ? -acc_nx : acc_nx;
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
      if (is_div) begin
         if (div_zero) begin
            res_hi = op_a;
            res_lo = {WIDTH{1'b1}};
         end else begin
            res_hi = rem;
            res_lo = quo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         op_a     <= '0;
         mcand    <= '0;
         acc      <= '0;
         sh       <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         if (accept_md) begin
            op_a     <= a;
            is_div   <= dec_div;
            div_zero <= dec_div & (b == '0);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            acc      <= '0;
            cnt      <= '0;
            sh       <= dec_div ? a_mag : b_mag;
            mcand    <= dec_div ? b_mag : a_mag;
         end else if (stepping) begin
            acc <= acc_nx;
            sh  <= sh_nx;
            cnt <= cnt + 1'b1;
         end
         if (finish) begin
            hi <= res_hi;
            lo <= res_lo;
         end else begin
            if (accept_mthi)
               hi <= a;
            if (accept_mtlo)
               lo <= a;
         end
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   always_comb begin
      rdata = '0;
      if (funct == F_MFHI)
         rdata = hi;
      else if (funct == F_MFLO)
         rdata = lo;
   end

endmodule
